ts_null_stuffer: RTL and testbench

- Output-rate stage between the 27 MHz read side of the output FIFO and the DATA_OUT/D_VALID_OUT pins.
- Turns the bursty packet stream into a constant-rate TS. It forwards whole 188-byte packets when one is fully buffered; otherwise it inserts null packets (PID 0x1FFF).
- Result: D_VALID stays high every cycle, which the ASI transmitter requires.
- Also re-aligns to P_SYNC, discarding stray bytes without breaking output packet framing.

---
 rtl/ts_null_stuffer_pkg.sv | 18 +
 rtl/ts_null_stuffer.sv | 130 +++++++++++++
 tb/tb_ts_null_stuffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_null_stuffer_pkg.sv
`timescale 1ns/1ps
// Shared transport-stream constants and the slot-state encoding used by the
// null stuffer.
package ts_defs;

   localparam int          TS_PKT_LEN   = 188;
   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
   localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;
   localparam logic [7:0]  TS_NULL_HDR3 = 8'h10;

   typedef enum logic [1:0] {
      S_DECIDE,
      S_PASS,
      S_NULL,
      S_DROP
   } slot_state_e;

endpackage

// File: rtl/ts_null_stuffer.sv
`timescale 1ns/1ps
// Constant-rate TS output stage: forwards buffered packets, fills gaps with null
// packets and re-aligns to P_SYNC. Optional NULL_CNT output under TS_STUFF_STATS_EN.
module ts_null_stuffer
   import ts_defs::*;
#(
   parameter int         PKT_LEN   = TS_PKT_LEN,
   parameter int         USEDW_W   = 10,
   parameter logic [7:0] NULL_FILL = 8'hFF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [7:0]         IN_DATA,
   input  logic               IN_PSYNC,
   input  logic               IN_EMPTY,
   input  logic [USEDW_W-1:0] IN_USEDW,
   output logic               RDREQ,
   output logic [7:0]         DATA_OUT,
   output logic               D_VALID_OUT,
   output logic               P_SYNC_OUT,
   output logic               RESYNC_PULSE
`ifdef TS_STUFF_STATS_EN
   ,
   output logic [15:0]        NULL_CNT
`endif
);

   localparam int                 CNT_W     = $clog2(PKT_LEN);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PKT_LEN - 1);
   localparam logic [USEDW_W-1:0] PKT_LEN_U = USEDW_W'(PKT_LEN);

   slot_state_e      state;
   slot_state_e      state_nxt;
   slot_state_e      decided;
   slot_state_e      slot_mode;
   logic [CNT_W-1:0] cnt;
   logic             drop_done;
   logic             drop_done_nxt;
   logic             drop_stopped;
   logic             pkt_ready;
   logic             rd;
   logic [7:0]       null_byte;
   logic [7:0]       data_nxt;

   // The decision is only meaningful in DECIDE (cnt==0); afterwards the held state rules.
   always_comb begin
      pkt_ready = (IN_USEDW >= PKT_LEN_U);
      decided   = S_NULL;
      if (pkt_ready && !IN_EMPTY && IN_PSYNC) begin
         decided = S_PASS;
      end else if (pkt_ready && !IN_PSYNC) begin
         decided = S_DROP;
      end
      slot_mode    = (state == S_DECIDE) ? decided : state;
      drop_stopped = (state == S_DECIDE) ? 1'b0 : drop_done;
   end

   always_comb begin
      null_byte = NULL_FILL;
      if (cnt == '0) begin
         null_byte = TS_SYNC_BYTE;
      end else if (cnt == CNT_W'(1)) begin
         null_byte = {3'b000, TS_NULL_PID[12:8]};
      end else if (cnt == CNT_W'(2)) begin
         null_byte = TS_NULL_PID[7:0];
      end else if (cnt == CNT_W'(3)) begin
         null_byte = TS_NULL_HDR3;
      end
   end

   // Once a DROP slot hits a sync head or runs dry it stops reading for the rest of the slot.
   always_comb begin
      state_nxt     = (cnt == CNT_LAST) ? S_DECIDE : slot_mode;
      rd            = 1'b0;
      data_nxt      = null_byte;
      drop_done_nxt = 1'b0;
      case (slot_mode)
         S_PASS: begin
            rd       = !IN_EMPTY;
            data_nxt = IN_EMPTY ? NULL_FILL : IN_DATA;
         end
         S_DROP: begin
            rd            = !drop_stopped && !IN_EMPTY && !IN_PSYNC;
            drop_done_nxt = !rd;
         end
         default: begin
         end
      endcase
   end

   assign RDREQ = rd & RST;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_DECIDE;
         cnt       <= '0;
         drop_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         drop_done <= drop_done_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         DATA_OUT     <= 8'h00;
         D_VALID_OUT  <= 1'b0;
         P_SYNC_OUT   <= 1'b0;
         RESYNC_PULSE <= 1'b0;
      end else begin
         DATA_OUT     <= data_nxt;
         D_VALID_OUT  <= 1'b1;
         P_SYNC_OUT   <= (cnt == '0);
         RESYNC_PULSE <= (state == S_DECIDE) && (decided == S_DROP);
      end
   end

`ifdef TS_STUFF_STATS_EN
   // Counts every slot that emitted a null packet, saturating rather than wrapping.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         NULL_CNT <= 16'h0000;
      end else if ((state == S_DECIDE) && (decided != S_PASS) && (NULL_CNT != 16'hFFFF)) begin
         NULL_CNT <= NULL_CNT + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_ts_null_stuffer.sv
`timescale 1ns/1ps
// Self-checking bench for ts_null_stuffer: a queue-based FIFO model feeds the DUT and a
// slot-level reference model predicts every output byte, flag and read request.
module tb_ts_null_stuffer;

   localparam int PKT = 188;
   localparam int M_NULL = 0;
   localparam int M_PASS = 1;
   localparam int M_DROP = 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] IN_DATA;
   logic       IN_PSYNC;
   logic       IN_EMPTY;
   logic [9:0] IN_USEDW;
   logic       RDREQ;
   logic [7:0] DATA_OUT;
   logic       D_VALID_OUT;
   logic       P_SYNC_OUT;
   logic       RESYNC_PULSE;

   logic [8:0] fifo[$];
   logic [8:0] src[$];

   int         n_vec;
   int         n_err;
   int         n_pops;
   int         n_resync;
   int         mpos;
   int         mmode;
   int         usedw_bias;
   int         usedw_now;
   bit         drop_stop;
   bit         have_exp;
   logic [7:0] exp_data;
   logic       exp_psync;
   logic       exp_resync;

   ts_null_stuffer dut (
      .CLK          (CLK),
      .RST          (RST),
      .IN_DATA      (IN_DATA),
      .IN_PSYNC     (IN_PSYNC),
      .IN_EMPTY     (IN_EMPTY),
      .IN_USEDW     (IN_USEDW),
      .RDREQ        (RDREQ),
      .DATA_OUT     (DATA_OUT),
      .D_VALID_OUT  (D_VALID_OUT),
      .P_SYNC_OUT   (P_SYNC_OUT),
      .RESYNC_PULSE (RESYNC_PULSE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] null_byte(input int pos);
      case (pos)
         0:       return 8'h47;
         1:       return 8'h1F;
         2:       return 8'hFF;
         3:       return 8'h10;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic drive_inputs();
      usedw_now = fifo.size() + usedw_bias;
      if (usedw_now > 1023) usedw_now = 1023;
      IN_USEDW = 10'(usedw_now);
      IN_EMPTY = (fifo.size() == 0);
      if (fifo.size() > 0) begin
         {IN_PSYNC, IN_DATA} = fifo[0];
      end else begin
         IN_PSYNC = 1'b0;
         IN_DATA  = 8'($urandom);
      end
   endtask

   task automatic add_pkt(input bit to_src, input bit idx_payload);
      logic [8:0] e;
      for (int i = 0; i < PKT; i++) begin
         if (i == 0) e = {1'b1, 8'h47};
         else e = {1'b0, idx_payload ? 8'(i) : 8'($urandom)};
         if (to_src) src.push_back(e);
         else fifo.push_back(e);
      end
   endtask

   // One clock of the reference model: check last cycle's outputs, predict this cycle.
   task automatic step(input int npush);
      logic       exp_rd;
      logic       rd_seen;
      logic [7:0] nb;
      @(negedge CLK);
      if (have_exp) begin
         n_vec++;
         if (DATA_OUT !== exp_data) begin
            n_err++;
            $display("[TB] FAIL data_out pos=%0d got=%h exp=%h", mpos, DATA_OUT, exp_data);
         end
         n_vec++;
         if (P_SYNC_OUT !== exp_psync) begin
            n_err++;
            $display("[TB] FAIL p_sync_out pos=%0d got=%b exp=%b", mpos, P_SYNC_OUT, exp_psync);
         end
         n_vec++;
         if (RESYNC_PULSE !== exp_resync) begin
            n_err++;
            $display("[TB] FAIL resync_pulse pos=%0d got=%b exp=%b", mpos, RESYNC_PULSE, exp_resync);
         end
         n_vec++;
         if (D_VALID_OUT !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL d_valid_out pos=%0d got=%b exp=1", mpos, D_VALID_OUT);
         end
      end
      if (RESYNC_PULSE === 1'b1) n_resync++;
      if (mpos == 0) begin
         drop_stop = 1'b0;
         if (usedw_now >= PKT && fifo.size() > 0 && fifo[0][8]) mmode = M_PASS;
         else if (usedw_now >= PKT) mmode = M_DROP;
         else mmode = M_NULL;
      end
      exp_rd = 1'b0;
      nb     = null_byte(mpos);
      if (mmode == M_PASS) begin
         if (fifo.size() > 0) begin
            exp_rd = 1'b1;
            nb     = fifo[0][7:0];
         end else begin
            nb = 8'hFF;
         end
      end else if (mmode == M_DROP) begin
         if (!drop_stop && fifo.size() > 0 && !fifo[0][8]) exp_rd = 1'b1;
         else drop_stop = 1'b1;
      end
      rd_seen = RDREQ;
      n_vec++;
      if (rd_seen !== exp_rd) begin
         n_err++;
         $display("[TB] FAIL rdreq pos=%0d mode=%0d got=%b exp=%b", mpos, mmode, rd_seen, exp_rd);
      end
      @(posedge CLK);
      #1;
      if (rd_seen === 1'b1 && fifo.size() > 0) begin
         void'(fifo.pop_front());
         n_pops++;
      end
      for (int i = 0; i < npush && src.size() > 0; i++) fifo.push_back(src.pop_front());
      drive_inputs();
      exp_data   = nb;
      exp_psync  = (mpos == 0);
      exp_resync = (mpos == 0) && (mmode == M_DROP);
      have_exp   = 1'b1;
      mpos       = (mpos + 1) % PKT;
   endtask

   task automatic run_to(input int pos);
      while (mpos != pos) step(0);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #1;
      n_vec++;
      if (DATA_OUT !== 8'h00) begin
         n_err++;
         $display("[TB] FAIL reset_data got=%h exp=00", DATA_OUT);
      end
      n_vec++;
      if (D_VALID_OUT !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL reset_dvalid got=%b exp=0", D_VALID_OUT);
      end
      n_vec++;
      if (P_SYNC_OUT !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL reset_psync got=%b exp=0", P_SYNC_OUT);
      end
      n_vec++;
      if (RESYNC_PULSE !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL reset_resync got=%b exp=0", RESYNC_PULSE);
      end
      n_vec++;
      if (RDREQ !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL reset_rdreq got=%b exp=0", RDREQ);
      end
      repeat (3) @(posedge CLK);
      #1;
      RST       = 1'b1;
      mpos      = 0;
      mmode     = M_NULL;
      drop_stop = 1'b0;
      have_exp  = 1'b0;
      drive_inputs();
   endtask

   task automatic test_null_idle();
      $display("[TB] idle null stream");
      repeat (2 * PKT + 4) step(0);
   endtask

   task automatic test_pass_two();
      int p0;
      $display("[TB] two aligned packets");
      run_to(100);
      add_pkt(1'b0, 1'b1);
      add_pkt(1'b0, 1'b1);
      drive_inputs();
      p0 = n_pops;
      run_to(0);
      repeat (2 * PKT + 20) step(0);
      n_vec++;
      if (n_pops - p0 != 2 * PKT) begin
         n_err++;
         $display("[TB] FAIL pass_two_pops got=%0d exp=%0d", n_pops - p0, 2 * PKT);
      end
   endtask

   task automatic test_usedw_edge();
      int p0;
      $display("[TB] usedw 187 at slot start");
      run_to(0);
      add_pkt(1'b1, 1'b0);
      repeat (PKT - 1) fifo.push_back(src.pop_front());
      drive_inputs();
      p0 = n_pops;
      step(1);
      repeat (PKT - 1) step(0);
      n_vec++;
      if (n_pops != p0) begin
         n_err++;
         $display("[TB] FAIL usedw_edge_null_pops got=%0d exp=0", n_pops - p0);
      end
      repeat (PKT) step(0);
      n_vec++;
      if (n_pops - p0 != PKT) begin
         n_err++;
         $display("[TB] FAIL usedw_edge_pass_pops got=%0d exp=%0d", n_pops - p0, PKT);
      end
   endtask

   task automatic test_resync();
      int p0;
      int r0;
      $display("[TB] resync over 5 stray bytes");
      run_to(50);
      repeat (5) fifo.push_back({1'b0, 8'($urandom)});
      add_pkt(1'b0, 1'b0);
      fifo.push_back({1'b1, 8'h47});
      repeat (6) fifo.push_back({1'b0, 8'($urandom)});
      drive_inputs();
      run_to(0);
      p0 = n_pops;
      r0 = n_resync;
      repeat (PKT) step(0);
      n_vec++;
      if (n_pops - p0 != 5) begin
         n_err++;
         $display("[TB] FAIL resync_drop_pops got=%0d exp=5", n_pops - p0);
      end
      n_vec++;
      if (n_resync - r0 != 1) begin
         n_err++;
         $display("[TB] FAIL resync_pulse_count got=%0d exp=1", n_resync - r0);
      end
      repeat (PKT) step(0);
      n_vec++;
      if (n_pops - p0 != 5 + PKT) begin
         n_err++;
         $display("[TB] FAIL resync_pass_pops got=%0d exp=%0d", n_pops - p0, 5 + PKT);
      end
      fifo.delete();
      drive_inputs();
   endtask

   task automatic test_underrun();
      int p0;
      $display("[TB] underrun inside pass slot");
      run_to(0);
      usedw_bias = 60;
      fifo.push_back({1'b1, 8'h47});
      repeat (129) fifo.push_back({1'b0, 8'($urandom)});
      drive_inputs();
      p0 = n_pops;
      repeat (5) step(0);
      usedw_bias = 0;
      drive_inputs();
      repeat (PKT - 5) step(0);
      n_vec++;
      if (n_pops - p0 != 130) begin
         n_err++;
         $display("[TB] FAIL underrun_pops got=%0d exp=130", n_pops - p0);
      end
      repeat (10) step(0);
   endtask

   task automatic test_reset_mid_pass();
      int p0;
      $display("[TB] reset at byte 100 of a pass slot");
      run_to(0);
      add_pkt(1'b0, 1'b0);
      add_pkt(1'b0, 1'b0);
      drive_inputs();
      run_to(100);
      test_reset();
      p0 = n_pops;
      repeat (3 * PKT) step(0);
      n_vec++;
      if (n_pops - p0 != PKT + 88) begin
         n_err++;
         $display("[TB] FAIL reset_recovery_pops got=%0d exp=%0d", n_pops - p0, PKT + 88);
      end
   endtask

   task automatic test_random_bursts();
      $display("[TB] random bursty stream");
      src.delete();
      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 12)) src.push_back({1'b0, 8'($urandom)});
         end else begin
            add_pkt(1'b1, 1'b0);
         end
      end
      repeat (4000) step($urandom_range(0, 2));
      repeat (4 * PKT) step(0);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      n_pops     = 0;
      n_resync   = 0;
      mpos       = 0;
      mmode      = M_NULL;
      usedw_bias = 0;
      drop_stop  = 1'b0;
      have_exp   = 1'b0;
      exp_data   = 8'h00;
      exp_psync  = 1'b0;
      exp_resync = 1'b0;
      RST        = 1'b1;
      drive_inputs();
      #2;
      test_reset();
      test_null_idle();
      test_pass_two();
      test_usedw_edge();
      test_resync();
      test_underrun();
      test_reset_mid_pass();
      test_random_bursts();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
